// File: rtl/eae_shift_unit_pkg.sv
// Shared EAE definitions: opcode and FSM state encodings, register-pair type,
// and the normalize-stop test used by NMI.
package eae_shift_unit_pkg;

    localparam int WORD_W = 12;
    localparam int SC_W   = 5;

    // Bit 0 is the MSB throughout, matching the CPU's register numbering.
    typedef logic [0:WORD_W-1] word_t;
    typedef logic [0:SC_W-1]   sc_t;

    typedef enum logic [2:0] {
        EAE_NOP = 3'd0,
        EAE_SHL = 3'd1,
        EAE_ASR = 3'd2,
        EAE_LSR = 3'd3,
        EAE_NMI = 3'd4
    } eae_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } eae_state_e;

    typedef struct packed {
        logic  link;
        word_t ac;
        word_t mq;
    } eae_regs_t;

    // NMI stops once the sign and first magnitude bit differ, or nothing
    // below them is left to shift up.
    function automatic logic nmi_normalized(input word_t ac, input word_t mq);
        return (ac[0] != ac[1]) || ({ac[2:WORD_W-1], mq} == '0);
    endfunction

endpackage

// File: rtl/eae_shift_step.sv
// One combinational shift step over {link, AC, MQ} for a given op; NMI callers
// pass EAE_SHL. Any other op returns the registers unchanged.
module eae_shift_step
    import eae_shift_unit_pkg::*;
(
    input  eae_op_e   op,
    input  eae_regs_t cur,
    output eae_regs_t nxt
);

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        nxt = cur;
        unique case (op)
            EAE_SHL: begin
                nxt.link = cur.ac[0];
                nxt.ac   = {cur.ac[1:WORD_W-1], cur.mq[0]};
                nxt.mq   = {cur.mq[1:WORD_W-1], 1'b0};
            end
            EAE_ASR: begin
                nxt.link = cur.ac[0];
                nxt.ac   = {cur.ac[0], cur.ac[0:WORD_W-2]};
                nxt.mq   = {cur.ac[WORD_W-1], cur.mq[0:WORD_W-2]};
            end
            EAE_LSR: begin
                nxt.link = 1'b0;
                nxt.ac   = {1'b0, cur.ac[0:WORD_W-2]};
                nxt.mq   = {cur.ac[WORD_W-1], cur.mq[0:WORD_W-2]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/eae_shift_unit.sv
// EAE mode-A shift/normalize engine: one bit per clock over AC:MQ, with step
// counter SC and a start/busy/done handshake toward the CPU execute state.
module eae_shift_unit
    import eae_shift_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:2]  op,
    input  logic [0:4]  count,
    input  logic [0:11] ac_in,
    input  logic [0:11] mq_in,
    input  logic        link_in,
    output logic        busy,
    output logic        done,
    output logic [0:11] ac_out,
    output logic [0:11] mq_out,
    output logic        link_out,
    output logic [0:4]  sc_out
);

    eae_state_e state_q, state_d;
    eae_op_e    op_q, op_d, op_sel, step_op;
    eae_regs_t  regs_q, regs_d, step_out;
    sc_t        sc_q, sc_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    assign op_sel  = eae_op_e'(op);
    assign step_op = (op_q == EAE_NMI) ? EAE_SHL : op_q;

    eae_shift_step u_step (
        .op  (step_op),
        .cur (regs_q),
        .nxt (step_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        regs_d  = regs_q;
        sc_d    = sc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // busy drops on the edge that ends the done pulse.
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    regs_d = '{link: link_in, ac: ac_in, mq: mq_in};
                    unique case (op_sel)
                        EAE_SHL, EAE_ASR, EAE_LSR: begin
                            op_d    = op_sel;
                            sc_d    = count;
                            state_d = ST_SHIFT;
                        end
                        EAE_NMI: begin
                            op_d    = EAE_NMI;
                            sc_d    = '0;
                            state_d = ST_SHIFT;
                        end
                        default: begin
                            op_d    = EAE_NOP;
                            sc_d    = '0;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                if (op_q == EAE_NMI) begin
                    if (nmi_normalized(regs_q.ac, regs_q.mq)) begin
                        state_d = ST_DONE;
                    end else begin
                        regs_d = step_out;
                        sc_d   = sc_q + 5'd1;
                    end
                end else begin
                    // count+1 steps: the step taken with SC==0 is the last.
                    regs_d = step_out;
                    if (sc_q == '0) state_d = ST_DONE;
                    else            sc_d    = sc_q - 5'd1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= EAE_NOP;
            regs_q  <= '0;
            sc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            regs_q  <= regs_d;
            sc_q    <= sc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ac_out   = regs_q.ac;
    assign mq_out   = regs_q.mq;
    assign link_out = regs_q.link;
    assign sc_out   = sc_q;

endmodule

// File: tb/tb_eae_shift_unit.sv
// Directed bench for eae_shift_unit: expected results go into a scoreboard
// queue at start and are popped and compared when done pulses.
module tb_eae_shift_unit;
    import eae_shift_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [0:2]  op;
    logic [0:4]  count;
    logic [0:11] ac_in, mq_in;
    logic        link_in;
    logic        busy, done;
    logic [0:11] ac_out, mq_out;
    logic        link_out;
    logic [0:4]  sc_out;

    typedef struct {
        string       tag;
        logic [0:11] ac;
        logic [0:11] mq;
        logic        link;
        logic [0:4]  sc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    eae_shift_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .count    (count),
        .ac_in    (ac_in),
        .mq_in    (mq_in),
        .link_in  (link_in),
        .busy     (busy),
        .done     (done),
        .ac_out   (ac_out),
        .mq_out   (mq_out),
        .link_out (link_out),
        .sc_out   (sc_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [0:11] ac, input logic [0:11] mq,
                                input logic link, input logic [0:4] sc, input int lat);
        exp_t e;
        e.tag = tag; e.ac = ac; e.mq = mq; e.link = link; e.sc = sc; e.lat = lat;
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  busy,        0);
        check({tag, "_done"},  done,        0);
        check({tag, "_ac"},    ac_out,      0);
        check({tag, "_mq"},    mq_out,      0);
        check({tag, "_link"},  link_out,    0);
        check({tag, "_sc"},    sc_out,      0);
        check({tag, "_state"}, dut.state_q, ST_IDLE);
    endtask

    // Issue one op; optionally pulse a second (to-be-ignored) start at cycle extra_at.
    task automatic run_op(input logic [2:0] o, input logic [4:0] cnt, input logic [0:11] ac,
                          input logic [0:11] mq, input logic lk, input exp_t e, input int extra_at);
        exp_t got;
        int   cycles;
        logic seen;
        sb.push_back(e);
        @(negedge clk);
        op = o; count = cnt; ac_in = ac; mq_in = mq; link_in = lk; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({e.tag, "_busy_acc"}, busy, 1);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            start = (cycles == extra_at);
            if (start) begin
                op = EAE_LSR; count = 5'd3; ac_in = 12'o5252; mq_in = 12'o1234; link_in = 1'b1;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({e.tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({e.tag, "_sb_nonempty"}, sb.size(), e.tag.len() > 0 ? sb.size() : 0);
            got = sb.pop_front();
            check({got.tag, "_lat"},  cycles,   got.lat);
            check({got.tag, "_ac"},   ac_out,   got.ac);
            check({got.tag, "_mq"},   mq_out,   got.mq);
            check({got.tag, "_link"}, link_out, got.link);
            check({got.tag, "_sc"},   sc_out,   got.sc);
            check({got.tag, "_busy_done"}, busy, 1);
            @(posedge clk); #1;
            check({got.tag, "_done_fall"}, done, 0);
            check({got.tag, "_busy_fall"}, busy, 0);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; count = '0;
        ac_in = '0; mq_in = '0; link_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        run_op(EAE_SHL, 5'd0,  12'o0001, 12'o4000, 1'b1, mk("shl_c0",   12'o0003, 12'o0000, 1'b0, 5'd0, 2),  -1);
        run_op(EAE_ASR, 5'd2,  12'o4000, 12'o0000, 1'b0, mk("asr_c2",   12'o7400, 12'o0000, 1'b1, 5'd0, 4),  -1);
        run_op(EAE_LSR, 5'd30, 12'o7777, 12'o7777, 1'b1, mk("lsr_c30",  12'o0000, 12'o0000, 1'b0, 5'd0, 32), -1);
        run_op(EAE_SHL, 5'd31, 12'o7777, 12'o7777, 1'b0, mk("shl_c31",  12'o0000, 12'o0000, 1'b0, 5'd0, 33), -1);
        run_op(EAE_ASR, 5'd31, 12'o4000, 12'o0000, 1'b0, mk("asr_c31",  12'o7777, 12'o7777, 1'b1, 5'd0, 33), -1);
        run_op(EAE_NMI, 5'd9,  12'o0000, 12'o0040, 1'b0, mk("nmi_17",   12'o2000, 12'o0000, 1'b0, 5'd17, 19), -1);
        run_op(EAE_NMI, 5'd0,  12'o0000, 12'o0001, 1'b0, mk("nmi_22",   12'o2000, 12'o0000, 1'b0, 5'd22, 24), -1);
        run_op(EAE_NMI, 5'd0,  12'o7777, 12'o7777, 1'b0, mk("nmi_neg",  12'o6000, 12'o0000, 1'b1, 5'd22, 24), -1);
        run_op(EAE_NMI, 5'd5,  12'o0000, 12'o0000, 1'b1, mk("nmi_zero", 12'o0000, 12'o0000, 1'b1, 5'd0, 2),  -1);
        run_op(EAE_NMI, 5'd5,  12'o3777, 12'o7777, 1'b0, mk("nmi_norm", 12'o3777, 12'o7777, 1'b0, 5'd0, 2),  -1);
        run_op(EAE_NOP, 5'd7,  12'o1234, 12'o5670, 1'b1, mk("nop",      12'o1234, 12'o5670, 1'b1, 5'd0, 1),  -1);
        run_op(3'd7,    5'd7,  12'o4321, 12'o0765, 1'b0, mk("rsvd7",    12'o4321, 12'o0765, 1'b0, 5'd0, 1),  -1);
        run_op(EAE_SHL, 5'd10, 12'o0001, 12'o4000, 1'b0, mk("shl_c10",  12'o6000, 12'o0000, 1'b0, 5'd0, 12), 3);

        // Repeat run aborted by reset at cycle 5.
        @(negedge clk);
        op = EAE_SHL; count = 5'd10; ac_in = 12'o0001; mq_in = 12'o4000; link_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b0;

        run_op(EAE_SHL, 5'd0,  12'o0001, 12'o4000, 1'b1, mk("post_rst", 12'o0003, 12'o0000, 1'b0, 5'd0, 2),  -1);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
